// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per clock.
// A single shared subtractor does every iteration; START/BUSY/DONE handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request a division (sampled only in IDLE)
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse when results are valid
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero, held like the results
module seq_divider #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] r_work;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // One restoring step. r_shift is WIDTH+1 bits; when its MSB is set it is
    // already >= 2^WIDTH > divisor, so a borrow is only possible with MSB clear,
    // in which case diff's MSB is the borrow.
    always_comb begin
        r_shift = {r_work, q_work[WIDTH-1]};
        diff    = r_shift - {1'b0, dvsr};
        borrow  = ~r_shift[WIDTH] & diff[WIDTH];
        r_step  = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_step  = {q_work[WIDTH-2:0], ~borrow};
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dvsr        <= '0;
            q_work      <= '0;
            r_work      <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvsr        <= divisor;
                        div_by_zero <= 1'b0;
                        if (divisor != '0) begin
                            q_work <= dividend;
                            r_work <= '0;
                            cnt    <= CNT_W'(WIDTH);
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            // Divide by zero resolves immediately with saturated quotient.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= FINISH;
                        end
                    end
                end
                CALC: begin
                    q_work <= q_step;
                    r_work <= r_step;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        quotient  <= q_step;
                        remainder <= r_step;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table, hand-written handshake/reset sequences
// and a random sweep; results are checked through an expected-result queue.
module tb_seq_divider;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    seq_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } sb_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               lat;
        int               busy_cyc;
    } vec_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_accept = 0;
    int  n_done   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model for an accepted operation.
    function automatic sb_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        sb_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every DONE pulse consumes one expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            sb_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("sb_quotient", 32'(quotient), 32'(e.q));
                check("sb_remainder", 32'(remainder), 32'(e.r));
                check("sb_div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                if (!e.dbz) begin
                    check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check("rem_lt_div", 32'(remainder < e.b), 32'(1));
                end
            end
        end
    end

    // Issue one operation from IDLE (called at a negedge) and wait for DONE.
    // With noise set, START is toggled randomly while the divider is busy.
    task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit noise,
                          output int lat, output int busy_cyc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb_q.push_back(model(a, b));
        n_accept++;
        lat      = -1;
        busy_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            dividend = WIDTH'($urandom);
            divisor  = WIDTH'($urandom);
            if (busy) busy_cyc++;
            if (done) begin
                lat = i;
                break;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        if (lat < 0) check("done_timeout", 32'(0), 32'(1));
        @(negedge clk);
    endtask

    vec_t vecs[7];
    int   lat;
    int   bc;
    int   done_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 8'd200, b: 8'd7,  q: 8'd28,  r: 8'd4,   dbz: 1'b0, lat: 9, busy_cyc: 8};
        vecs[1] = '{a: 8'd255, b: 8'd1,  q: 8'd255, r: 8'd0,   dbz: 1'b0, lat: 9, busy_cyc: 8};
        vecs[2] = '{a: 8'd5,   b: 8'd9,  q: 8'd0,   r: 8'd5,   dbz: 1'b0, lat: 9, busy_cyc: 8};
        vecs[3] = '{a: 8'd0,   b: 8'd3,  q: 8'd0,   r: 8'd0,   dbz: 1'b0, lat: 9, busy_cyc: 8};
        vecs[4] = '{a: 8'd100, b: 8'd0,  q: 8'hFF,  r: 8'd100, dbz: 1'b1, lat: 1, busy_cyc: 0};
        vecs[5] = '{a: 8'd10,  b: 8'd3,  q: 8'd3,   r: 8'd1,   dbz: 1'b0, lat: 9, busy_cyc: 8};
        vecs[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,  r: 8'd0,   dbz: 1'b0, lat: 9, busy_cyc: 8};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state.
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_div_by_zero", 32'(div_by_zero), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with latency, busy occupancy and hold checks.
        foreach (vecs[i]) begin
            do_div(vecs[i].a, vecs[i].b, 1'b0, lat, bc);
            check("vec_latency", 32'(lat), 32'(vecs[i].lat));
            check("vec_busy_cycles", 32'(bc), 32'(vecs[i].busy_cyc));
            check("vec_busy_after", 32'(busy), 32'(0));
            check("vec_done_after", 32'(done), 32'(0));
            repeat (3) @(negedge clk);
            check("vec_hold_quotient", 32'(quotient), 32'(vecs[i].q));
            check("vec_hold_remainder", 32'(remainder), 32'(vecs[i].r));
            check("vec_hold_dbz", 32'(div_by_zero), 32'(vecs[i].dbz));
        end

        // START pulses during CALC (cycle 3) and on the DONE cycle (9) are lost.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        sb_q.push_back(model(8'd200, 8'd7));
        n_accept++;
        done_seen = 0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (done) begin
                done_seen++;
                check("ignore_done_cycle", 32'(i), 32'(9));
            end
            if (i == 3 || i == 9) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore_done_count", 32'(done_seen), 32'(1));
        check("ignore_busy_idle", 32'(busy), 32'(0));
        check("ignore_quotient", 32'(quotient), 32'(28));
        check("ignore_remainder", 32'(remainder), 32'(4));
        do_div(8'd9, 8'd3, 1'b0, lat, bc);
        check("third_start_latency", 32'(lat), 32'(9));
        check("third_start_quotient", 32'(quotient), 32'(3));

        // Asynchronous reset in the middle of CALC.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", 32'(busy), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_done", 32'(done), 32'(0));
        check("async_rst_quotient", 32'(quotient), 32'(0));
        check("async_rst_remainder", 32'(remainder), 32'(0));
        check("async_rst_dbz", 32'(div_by_zero), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'(0));
        do_div(8'd50, 8'd6, 1'b0, lat, bc);
        check("post_reset_quotient", 32'(quotient), 32'(8));
        check("post_reset_remainder", 32'(remainder), 32'(2));

        // Random sweep, with occasional zero divisors and START noise while busy.
        for (int n = 0; n < 2000; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 19) == 0) ? WIDTH'(0) : WIDTH'($urandom);
            do_div(ra, rb, 1'($urandom_range(0, 1)), lat, bc);
            check("rand_latency", 32'(lat), (rb == '0) ? 32'(1) : 32'(WIDTH + 1));
        end

        repeat (3) @(negedge clk);
        check("done_count", 32'(n_done), 32'(n_accept));
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
